// File: rtl/car_actuator.sv
// Vehicle-side actuator: ramps car_speed on a prescaled tick under a drive FSM,
// and runs a door FSM interlocked against motion and speed.
module car_actuator #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned ACCEL_STEP = 2,
  parameter int unsigned DECEL_STEP = 4,
  parameter int unsigned MAX_SPEED  = 200,
  parameter int unsigned DOOR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accelerate_car,
  input  logic       unlock_door,
  input  logic       door_open_req,
  output logic [7:0] car_speed,
  output logic [1:0] drive_state,
  output logic [1:0] door_state,
  output logic       door_open,
  output logic       at_max
);

  localparam logic [1:0] DRV_IDLE  = 2'b00;
  localparam logic [1:0] DRV_ACCEL = 2'b01;
  localparam logic [1:0] DRV_BRAKE = 2'b10;

  localparam logic [1:0] DOOR_LOCKED   = 2'b00;
  localparam logic [1:0] DOOR_UNLOCKED = 2'b01;
  localparam logic [1:0] DOOR_OPEN     = 2'b10;
  localparam logic [1:0] DOOR_CLOSING  = 2'b11;

  // Close counter only has to reach DOOR_DELAY-1.
  localparam int unsigned CW = (DOOR_DELAY > 1) ? $clog2(DOOR_DELAY) : 1;

  logic [7:0]    tick_cnt;
  logic          tick;
  logic [CW-1:0] close_cnt;
  logic [CW-1:0] close_cnt_next;
  logic [1:0]    drive_next;
  logic [1:0]    door_next;
  logic [7:0]    speed_next;
  logic [8:0]    accel_sum;

  assign tick = (tick_cnt == 8'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  // NOTE: every register here is reset asynchronously; there is no memory
  // array, so nothing is left to come up undefined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  // Drive FSM; the door interlock masks acceleration unless locked.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    drive_next = DRV_IDLE;
    if (accelerate_car && (door_state == DOOR_LOCKED)) begin
      drive_next = DRV_ACCEL;
    end else if (car_speed != 8'd0) begin
      drive_next = DRV_BRAKE;
    end
  end

  // Accelerate in 9 bits so the saturation compare never sees a wrapped sum.
  assign accel_sum = {1'b0, car_speed} + 9'(ACCEL_STEP);

  always_comb begin
    speed_next = car_speed;
    if (tick) begin
      case (drive_state)
        DRV_ACCEL: begin
          if (accel_sum >= 9'(MAX_SPEED)) begin
            speed_next = 8'(MAX_SPEED);
          end else begin
            speed_next = accel_sum[7:0];
          end
        end
        DRV_BRAKE: begin
          if (car_speed <= 8'(DECEL_STEP)) begin
            speed_next = 8'd0;
          end else begin
            speed_next = car_speed - 8'(DECEL_STEP);
          end
        end
        default: speed_next = car_speed;
      endcase
    end
  end

  always_comb begin
    door_next      = door_state;
    close_cnt_next = close_cnt;
    case (door_state)
      DOOR_LOCKED: begin
        if (unlock_door && (car_speed == 8'd0)) begin
          door_next = DOOR_UNLOCKED;
        end
      end
      DOOR_UNLOCKED: begin
        if (door_open_req) begin
          door_next = DOOR_OPEN;
        end else if (!unlock_door) begin
          door_next = DOOR_LOCKED;
        end
      end
      DOOR_OPEN: begin
        if (!door_open_req) begin
          door_next      = DOOR_CLOSING;
          close_cnt_next = '0;
        end
      end
      default: begin
        // Reopen wins over completing the close in the same cycle.
        if (door_open_req && unlock_door) begin
          door_next      = DOOR_OPEN;
          close_cnt_next = '0;
        end else if (close_cnt == CW'(DOOR_DELAY - 1)) begin
          door_next      = DOOR_LOCKED;
          close_cnt_next = '0;
        end else begin
          close_cnt_next = close_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_speed   <= 8'd0;
      drive_state <= DRV_IDLE;
      door_state  <= DOOR_LOCKED;
      close_cnt   <= '0;
    end else begin
      car_speed   <= speed_next;
      drive_state <= drive_next;
      door_state  <= door_next;
      close_cnt   <= close_cnt_next;
    end
  end

  assign door_open = (door_state == DOOR_OPEN);
  assign at_max    = (car_speed == 8'(MAX_SPEED));

endmodule

// File: tb/tb_car_actuator.sv
// Bench for car_actuator: directed scenarios plus random traffic, each cycle
// compared against a cycle-level behavioural model of the vehicle.
module tb_car_actuator;

  localparam int TICK_DIV   = 4;
  localparam int ACCEL_STEP = 2;
  localparam int DECEL_STEP = 4;
  localparam int MAX_SPEED  = 200;
  localparam int DOOR_DELAY = 3;

  localparam int DR_IDLE = 0, DR_ACCEL = 1, DR_BRAKE = 2;
  localparam int DR_LOCKED = 0, DR_UNLOCKED = 1, DR_OPEN = 2, DR_CLOSING = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       accelerate_car = 1'b0;
  logic       unlock_door = 1'b0;
  logic       door_open_req = 1'b0;
  logic [7:0] car_speed;
  logic [1:0] drive_state;
  logic [1:0] door_state;
  logic       door_open;
  logic       at_max;

  car_actuator #(
    .TICK_DIV  (TICK_DIV),
    .ACCEL_STEP(ACCEL_STEP),
    .DECEL_STEP(DECEL_STEP),
    .MAX_SPEED (MAX_SPEED),
    .DOOR_DELAY(DOOR_DELAY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .accelerate_car(accelerate_car),
    .unlock_door   (unlock_door),
    .door_open_req (door_open_req),
    .car_speed     (car_speed),
    .drive_state   (drive_state),
    .door_state    (door_state),
    .door_open     (door_open),
    .at_max        (at_max)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: speed, mode, door position, edges since reset release,
  // and how many cycles the door has been closing.
  int m_speed, m_drive, m_door, m_edges, m_close_age;

  task automatic model_reset();
    m_speed = 0; m_drive = DR_IDLE; m_door = DR_LOCKED; m_edges = 0; m_close_age = 0;
  endtask

  task automatic model_edge();
    int  s;
    int  nd;
    bit  tick;
    s    = m_speed;
    tick = (m_edges % TICK_DIV) == (TICK_DIV - 1);
    m_edges++;
    if (tick && m_drive == DR_ACCEL)
      m_speed = (s + ACCEL_STEP > MAX_SPEED) ? MAX_SPEED : s + ACCEL_STEP;
    else if (tick && m_drive == DR_BRAKE)
      m_speed = (s <= DECEL_STEP) ? 0 : s - DECEL_STEP;
    nd = m_door;
    case (m_door)
      DR_LOCKED:   if (unlock_door && s == 0) nd = DR_UNLOCKED;
      DR_UNLOCKED: if (door_open_req) nd = DR_OPEN; else if (!unlock_door) nd = DR_LOCKED;
      DR_OPEN:     if (!door_open_req) begin nd = DR_CLOSING; m_close_age = 1; end
      default: begin
        if (door_open_req && unlock_door) nd = DR_OPEN;
        else if (m_close_age >= DOOR_DELAY) nd = DR_LOCKED;
        else m_close_age++;
      end
    endcase
    if (accelerate_car && m_door == DR_LOCKED) m_drive = DR_ACCEL;
    else if (s != 0) m_drive = DR_BRAKE;
    else m_drive = DR_IDLE;
    m_door = nd;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".speed"}, car_speed, m_speed);
    check({tag, ".drive"}, drive_state, m_drive);
    check({tag, ".door"}, door_state, m_door);
    check({tag, ".door_open"}, door_open, (m_door == DR_OPEN));
    check({tag, ".at_max"}, at_max, (m_speed == MAX_SPEED));
  endtask

  // Starts and ends on a falling edge; inputs are stable across the rising edge.
  task automatic cycle(input logic a, input logic u, input logic o, input string tag);
    accelerate_car = a;
    unlock_door    = u;
    door_open_req  = o;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, ".rst_speed"}, car_speed, 0);
    check({tag, ".rst_drive"}, drive_state, DR_IDLE);
    check({tag, ".rst_door"}, door_state, DR_LOCKED);
    check({tag, ".rst_door_open"}, door_open, 0);
    check({tag, ".rst_at_max"}, at_max, 0);
    model_reset();
    accelerate_car = 1'b0;
    unlock_door    = 1'b0;
    door_open_req  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen[$];
    logic a, u, o;
    model_reset();
    @(negedge clk);
    pulse_reset("init");

    // Reset mid-motion at speed 40.
    n = 0;
    while (car_speed != 8'd40 && n < 200) begin cycle(1, 0, 0, "to40"); n++; end
    check("reach_40", car_speed, 40);
    pulse_reset("midmotion");

    // Ramp and saturate.
    for (int i = 0; i < 500; i++) cycle(1, 0, 0, "ramp");
    check("sat_speed", car_speed, MAX_SPEED);
    check("sat_at_max", at_max, 1);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, "sat_hold");
    check("sat_hold_speed", car_speed, MAX_SPEED);

    // Braking floor from 10.
    pulse_reset("pre_brake");
    n = 0;
    while (car_speed != 8'd10 && n < 100) begin cycle(1, 0, 0, "to10"); n++; end
    check("reach_10", car_speed, 10);
    n = 0;
    while (car_speed != 8'd0 && n < 40) begin
      cycle(0, 0, 0, "brake");
      if (seen.size() == 0 || seen[$] != int'(car_speed)) seen.push_back(int'(car_speed));
      n++;
    end
    check("brake_steps", seen.size(), 4);
    if (seen.size() == 4) begin
      check("brake_s0", seen[0], 10);
      check("brake_s1", seen[1], 6);
      check("brake_s2", seen[2], 2);
      check("brake_s3", seen[3], 0);
    end
    cycle(0, 0, 0, "brake_idle");
    check("brake_idle_drive", drive_state, DR_IDLE);
    check("brake_no_wrap", car_speed, 0);

    // Unlock interlock while braking from 6.
    pulse_reset("pre_unlock");
    n = 0;
    while (car_speed != 8'd10 && n < 100) begin cycle(1, 0, 0, "to10b"); n++; end
    n = 0;
    while (car_speed != 8'd6 && n < 20) begin cycle(0, 0, 0, "to6"); n++; end
    check("reach_6", car_speed, 6);
    n = 0;
    while (car_speed != 8'd0 && n < 40) begin
      cycle(0, 1, 0, "unlock_wait");
      n++;
    end
    check("unlock_held_locked", door_state, DR_LOCKED);
    cycle(0, 1, 0, "unlock_go");
    check("unlock_now", door_state, DR_UNLOCKED);

    // Open door blocks acceleration.
    cycle(0, 1, 1, "open");
    check("open_state", door_state, DR_OPEN);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 1, "open_accel");
      check("open_speed", car_speed, 0);
      check("open_drive", drive_state, DR_IDLE);
    end

    // Closing runs DOOR_DELAY cycles, then locks.
    for (int i = 0; i < DOOR_DELAY; i++) begin
      cycle(0, 0, 0, "close");
      check("closing", door_state, DR_CLOSING);
    end
    cycle(0, 0, 0, "close_done");
    check("closed_locked", door_state, DR_LOCKED);

    // Reopen on closing cycle 2, then a full close from scratch.
    cycle(0, 1, 0, "re_unlock");
    cycle(0, 1, 1, "re_open");
    cycle(0, 0, 0, "re_close1");
    cycle(0, 0, 0, "re_close2");
    check("re_close2_state", door_state, DR_CLOSING);
    cycle(0, 1, 1, "reopen");
    check("reopen_state", door_state, DR_OPEN);
    for (int i = 0; i < DOOR_DELAY; i++) begin
      cycle(0, 0, 0, "re_close");
      check("re_closing", door_state, DR_CLOSING);
    end
    cycle(0, 0, 0, "re_close_done");
    check("re_closed_locked", door_state, DR_LOCKED);

    // Simultaneous unlock and accelerate: one ACCEL cycle without, then with, a tick.
    for (int k = 0; k < 2; k++) begin
      pulse_reset("simul");
      for (int i = 0; i < 2 * k; i++) cycle(0, 0, 0, "simul_pad");
      cycle(1, 1, 0, "simul_edge");
      check("simul_door", door_state, DR_UNLOCKED);
      check("simul_drive", drive_state, DR_ACCEL);
      for (int i = 0; i < 6; i++) begin
        cycle(1, 1, 0, "simul_after");
        check("simul_bounded", (car_speed <= 8'(ACCEL_STEP)), 1);
      end
    end

    // Random traffic with occasional asynchronous resets.
    pulse_reset("pre_rand");
    a = 0; u = 0; o = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) a = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) u = 1'($urandom_range(1));
      if ($urandom_range(11) == 0) o = ($urandom_range(2) == 0);
      if ($urandom_range(499) == 0) pulse_reset("rand_rst");
      else cycle(a, u, o, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
